// File: rtl/bmc_sched.sv
// Control scheduler for a time-shared Viterbi ACS array: it accepts symbol pairs,
// steps the ACS groups, and sequences path-metric normalisation and traceback.
module bmc_sched #(
   parameter int N_GRP     = 4,
   parameter int GRP_W     = 2,
   parameter int FRAME_LEN = 64,
   parameter int STG_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [1:0]       rx_pair,
   output logic             rx_ready,
   input  logic             frame_start,
   output logic [1:0]       bmc_pair,
   output logic             acs_en,
   output logic [GRP_W-1:0] acs_grp,
   output logic [STG_W-1:0] stage_cnt,
   input  logic             norm_req,
   output logic             norm_en,
   output logic             tb_start,
   input  logic             tb_done,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPUTE,
      S_NORM,
      S_TB_WAIT
   } state_t;

   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GRP - 1);
   localparam logic [STG_W-1:0] LAST_STG = STG_W'(FRAME_LEN - 1);

   state_t           r_state, w_state_next;
   logic [GRP_W-1:0] r_grp, w_grp_next;
   logic [STG_W-1:0] r_stage, w_stage_next;
   // Remembers that the final stage completed, so NORM can route to traceback
   // even when FRAME_LEN does not fit in the stage counter.
   logic             r_full, w_full_next;
   logic [1:0]       r_pair;
   logic             r_acs_en, r_norm_en, r_tb_start;
   logic             w_last_grp, w_last_stage, w_xfer;

   assign w_last_grp   = (r_grp == LAST_GRP);
   assign w_last_stage = (r_stage == LAST_STG);

   assign rx_ready = (r_state == S_IDLE) ||
                     ((r_state == S_COMPUTE) && w_last_grp && !norm_req && !w_last_stage);
   assign w_xfer   = rx_valid && rx_ready && !frame_start;

   always_comb begin
      w_state_next = r_state;
      w_grp_next   = r_grp;
      w_stage_next = r_stage;
      w_full_next  = r_full;
      if (frame_start && (r_state != S_TB_WAIT)) begin
         w_state_next = S_IDLE;
         w_grp_next   = '0;
         w_stage_next = '0;
         w_full_next  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  w_state_next = S_COMPUTE;
                  w_grp_next   = '0;
               end
            end
            S_COMPUTE: begin
               if (!w_last_grp) begin
                  w_grp_next = r_grp + GRP_W'(1);
               end else begin
                  w_grp_next   = '0;
                  w_stage_next = r_stage + STG_W'(1);
                  w_full_next  = w_last_stage;
                  if (norm_req)          w_state_next = S_NORM;
                  else if (w_last_stage) w_state_next = S_TB_WAIT;
                  else if (w_xfer)       w_state_next = S_COMPUTE;
                  else                   w_state_next = S_IDLE;
               end
            end
            S_NORM: begin
               w_state_next = r_full ? S_TB_WAIT : S_IDLE;
            end
            S_TB_WAIT: begin
               if (tb_done) begin
                  w_state_next = S_IDLE;
                  w_stage_next = '0;
                  w_full_next  = 1'b0;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_grp      <= '0;
         r_stage    <= '0;
         r_full     <= 1'b0;
         r_pair     <= 2'b00;
         r_acs_en   <= 1'b0;
         r_norm_en  <= 1'b0;
         r_tb_start <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_grp      <= w_grp_next;
         r_stage    <= w_stage_next;
         r_full     <= w_full_next;
         if (w_xfer) r_pair <= rx_pair;
         r_acs_en   <= (w_state_next == S_COMPUTE);
         r_norm_en  <= (w_state_next == S_NORM);
         r_tb_start <= (w_state_next == S_TB_WAIT) && (r_state != S_TB_WAIT);
      end
   end

   assign bmc_pair  = r_pair;
   assign acs_en    = r_acs_en;
   assign acs_grp   = r_grp;
   assign stage_cnt = r_stage;
   assign norm_en   = r_norm_en;
   assign tb_start  = r_tb_start;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bmc_sched.sv
// Directed and random checks of bmc_sched against a cycle-level behavioural model
// (N_GRP = 4, FRAME_LEN = 4).
module tb_bmc_sched;
   localparam int NG = 4;
   localparam int FL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [1:0] rx_pair = 2'b00;
   logic       rx_ready;
   logic       frame_start = 1'b0;
   logic [1:0] bmc_pair;
   logic       acs_en;
   logic [1:0] acs_grp;
   logic [2:0] stage_cnt;
   logic       norm_req = 1'b0;
   logic       norm_en;
   logic       tb_start;
   logic       tb_done = 1'b0;
   logic       busy;

   bmc_sched #(.N_GRP(NG), .GRP_W(2), .FRAME_LEN(FL), .STG_W(3)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_pair(rx_pair), .rx_ready(rx_ready),
      .frame_start(frame_start), .bmc_pair(bmc_pair), .acs_en(acs_en), .acs_grp(acs_grp),
      .stage_cnt(stage_cnt), .norm_req(norm_req), .norm_en(norm_en), .tb_start(tb_start),
      .tb_done(tb_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: mg = group being computed (-1 when not computing), ms = stages done,
   // mnorm = in the normalisation cycle, mtb = cycles spent waiting for traceback (-1 = not waiting).
   int         mg, ms, mtb;
   bit         mnorm;
   logic [1:0] mpair;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mg = -1; ms = 0; mtb = -1; mnorm = 1'b0; mpair = 2'b00;
   endtask

   function automatic bit model_idle();
      return (mg < 0) && !mnorm && (mtb < 0);
   endfunction

   task automatic check_outputs();
      bit exp_ready;
      exp_ready = model_idle() || ((mg == NG-1) && !norm_req && (ms != FL-1));
      chk("rx_ready", 32'(rx_ready), 32'(exp_ready));
      chk("acs_en", 32'(acs_en), 32'(mg >= 0));
      chk("acs_grp", 32'(acs_grp), (mg >= 0) ? mg : 0);
      chk("stage_cnt", 32'(stage_cnt), ms);
      chk("norm_en", 32'(norm_en), 32'(mnorm));
      chk("tb_start", 32'(tb_start), 32'(mtb == 0));
      chk("busy", 32'(busy), 32'(!model_idle()));
      chk("bmc_pair", 32'(bmc_pair), 32'(mpair));
   endtask

   task automatic model_step(input bit fs, input bit rv, input logic [1:0] rp,
                             input bit nr, input bit td);
      bit rdy, xfer;
      rdy  = model_idle() || ((mg == NG-1) && !nr && (ms != FL-1));
      xfer = rv && rdy && !fs;
      if (xfer) begin
         mpair = rp;
         $display("xfer t=%0t pair=%b stage=%0d", $time, rp, ms);
      end
      if (fs && (mtb < 0)) begin
         mg = -1; ms = 0; mnorm = 1'b0;
      end else if (mtb >= 0) begin
         if (td) begin mtb = -1; ms = 0; end
         else mtb++;
      end else if (mnorm) begin
         mnorm = 1'b0;
         if (ms == FL) mtb = 0;
      end else if (mg >= 0) begin
         if (mg < NG-1) mg++;
         else begin
            ms++;
            if (nr) begin mg = -1; mnorm = 1'b1; end
            else if (ms == FL) begin mg = -1; mtb = 0; end
            else if (xfer) mg = 0;
            else mg = -1;
         end
      end else if (xfer) begin
         mg = 0;
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check, then advance model and DUT.
   task automatic cyc(input bit fs, input bit rv, input logic [1:0] rp, input bit nr, input bit td);
      frame_start = fs; rx_valid = rv; rx_pair = rp; norm_req = nr; tb_done = td;
      #1;
      check_outputs();
      model_step(fs, rv, rp, nr, td);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic stage_run(input logic [1:0] rp, input bit nr_last);
      cyc(0, 1, rp, 0, 0);
      for (int g = 0; g < NG-1; g++) cyc(0, 0, 2'b00, 0, 0);
      cyc(0, 0, 2'b00, nr_last, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [1:0] syms [3];

   initial begin
      model_reset();
      syms[0] = 2'b00; syms[1] = 2'b01; syms[2] = 2'b10;

      @(negedge clk);
      do_reset();

      // Single symbol: four ACS cycles, then one completed stage and idle.
      cyc(0, 1, 2'b10, 0, 0);
      for (int i = 0; i < NG; i++) cyc(0, 0, 2'b00, 0, 0);
      chk("single_stage_cnt", 32'(stage_cnt), 1);
      chk("single_busy", 32'(busy), 0);
      chk("single_pair", 32'(bmc_pair), 32'(2'b10));

      // Back-to-back symbols with rx_valid held high.
      cyc(1, 0, 2'b00, 0, 0);
      for (int i = 0; i < 9; i++) cyc(0, 1, syms[i / 4], 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 0, 0);
      chk("b2b_acs_en_last", 32'(acs_en), 1);
      cyc(0, 0, 2'b00, 0, 0);
      chk("b2b_stage_cnt", 32'(stage_cnt), 3);
      chk("b2b_acs_off", 32'(acs_en), 0);

      // Final stage leads to traceback; input is refused until tb_done.
      cyc(0, 1, 2'b11, 0, 0);
      for (int i = 0; i < NG; i++) cyc(0, 1, 2'b01, 0, 0);
      chk("tb_start_first", 32'(tb_start), 1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 2'b01, 0, 0);
      chk("tb_wait_ready", 32'(rx_ready), 0);
      cyc(0, 0, 2'b00, 0, 1);
      chk("tb_done_stage", 32'(stage_cnt), 0);
      chk("tb_done_busy", 32'(busy), 0);

      // Normalisation requested at the end of stage 2.
      stage_run(2'b01, 0);
      stage_run(2'b10, 0);
      stage_run(2'b11, 1);
      chk("norm_en_pulse", 32'(norm_en), 1);
      chk("norm_acs_off", 32'(acs_en), 0);
      chk("norm_ready", 32'(rx_ready), 0);
      cyc(0, 1, 2'b00, 0, 0);
      chk("norm_then_idle", 32'(busy), 0);
      chk("norm_stage_cnt", 32'(stage_cnt), 3);

      // frame_start at group 2 of stage 1 wins over rx_valid.
      cyc(1, 0, 2'b00, 0, 0);
      stage_run(2'b10, 0);
      cyc(0, 1, 2'b01, 0, 0);
      cyc(0, 0, 2'b00, 0, 0);
      cyc(0, 0, 2'b00, 0, 0);
      cyc(1, 1, 2'b11, 0, 0);
      chk("fs_busy", 32'(busy), 0);
      chk("fs_stage_cnt", 32'(stage_cnt), 0);
      chk("fs_no_xfer", 32'(bmc_pair), 32'(2'b01));
      cyc(0, 1, 2'b11, 0, 0);
      chk("fs_restart_grp", 32'(acs_grp), 0);
      chk("fs_restart_en", 32'(acs_en), 1);
      for (int i = 0; i < NG; i++) cyc(0, 0, 2'b00, 0, 0);

      // Normalisation on the last stage, then reset while traceback is starting.
      cyc(1, 0, 2'b00, 0, 0);
      stage_run(2'b00, 0);
      stage_run(2'b01, 0);
      stage_run(2'b10, 0);
      stage_run(2'b11, 1);
      chk("last_norm_en", 32'(norm_en), 1);
      cyc(0, 0, 2'b00, 1, 0);
      chk("last_norm_tb_start", 32'(tb_start), 1);
      norm_req = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) cyc(0, 0, 2'b00, 1, 1);

      // tb_done in the same cycle as tb_start.
      stage_run(2'b00, 0);
      stage_run(2'b01, 0);
      stage_run(2'b10, 0);
      stage_run(2'b11, 0);
      cyc(0, 0, 2'b00, 0, 1);
      chk("tb_same_cycle_busy", 32'(busy), 0);
      chk("tb_same_cycle_stage", 32'(stage_cnt), 0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 1) begin
            rx_valid = 1'($urandom_range(0, 1));
            do_reset();
         end else begin
            cyc(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 70),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 99) < 12),
                1'($urandom_range(0, 99) < 30));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bmc_sched.md
BMC_SCHED -- requirements
Module: bmc_sched

Interface
REQ-001 Parameter N_GRP, default 4: number of ACS groups time-shared per trellis stage; must be a power of 2 and at least 2.
REQ-002 Parameter GRP_W, default 2: log2(N_GRP).
REQ-003 Parameter FRAME_LEN, default 64: trellis stages per frame; must be at least 2.
REQ-004 Parameter STG_W, default 6: stage counter width; 2^STG_W >= FRAME_LEN.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port rx_valid, input, 1: received symbol pair available.
REQ-008 Port rx_pair, input, 2: received hard-decision symbol pair.
REQ-009 Port rx_ready, output, 1: block accepts rx_pair this cycle.
REQ-010 Port frame_start, input, 1: one-cycle pulse that aborts and restarts the frame.
REQ-011 Port bmc_pair, output, 2: registered symbol pair driving all BMC instances.
REQ-012 Port acs_en, output, 1: selected ACS group updates this cycle.
REQ-013 Port acs_grp, output, GRP_W: index of the active ACS group.
REQ-014 Port stage_cnt, output, STG_W: completed stages in the current frame.
REQ-015 Port norm_req, input, 1: some path metric is above the normalisation threshold.
REQ-016 Port norm_en, output, 1: one-cycle pulse that makes the ACS array subtract its threshold.
REQ-017 Port tb_start, output, 1: one-cycle pulse that starts traceback.
REQ-018 Port tb_done, input, 1: traceback finished.
REQ-019 Port busy, output, 1: high in every state except IDLE.

Function
REQ-020 The block SHALL have four states: IDLE, COMPUTE, NORM, TB_WAIT.
REQ-021 Symbol acceptance: a transfer occurs when rx_valid and rx_ready are both high; bmc_pair SHALL load rx_pair on that edge.
REQ-022 bmc_pair SHALL hold its value until the next transfer.
REQ-023 rx_ready SHALL be high in IDLE.
REQ-024 rx_ready SHALL also be high in COMPUTE when acs_grp = N_GRP-1, norm_req = 0 and stage_cnt != FRAME_LEN-1; it SHALL be low otherwise.
REQ-025 IDLE: a transfer SHALL move the block to COMPUTE with acs_grp = 0.
REQ-026 COMPUTE: acs_en SHALL be 1; acs_grp SHALL step 0..N_GRP-1, one value per cycle.
REQ-027 Latency: for a transfer at edge T, acs_en with acs_grp = 0 SHALL be seen in cycle T+1 and acs_grp = N_GRP-1 in cycle T+N_GRP.
REQ-028 End of stage, at the edge leaving the acs_grp = N_GRP-1 cycle: stage_cnt SHALL increment.
REQ-029 At that edge, if norm_req = 1 the next state SHALL be NORM.
REQ-030 At that edge, else if the stage was stage FRAME_LEN-1 the next state SHALL be TB_WAIT.
REQ-031 At that edge, else if a transfer occurs the next state SHALL be COMPUTE with acs_grp = 0 (no bubble).
REQ-032 At that edge, otherwise the next state SHALL be IDLE.
REQ-033 Throughput: back-to-back input SHALL sustain one symbol per N_GRP cycles.
REQ-034 NORM: norm_en SHALL be 1 for exactly one cycle and acs_en SHALL be 0.
REQ-035 From NORM the next state SHALL be TB_WAIT if stage_cnt = FRAME_LEN, else IDLE.
REQ-036 Normalisation SHALL take priority over traceback when both are due in the same stage.
REQ-037 TB_WAIT: tb_start SHALL be 1 only in the first cycle of TB_WAIT.
REQ-038 On tb_done = 1 in TB_WAIT, stage_cnt SHALL become 0 and the next state SHALL be IDLE.
REQ-039 A tb_done pulse in the same cycle as tb_start SHALL be honoured.
REQ-040 tb_done outside TB_WAIT SHALL be ignored.
REQ-041 frame_start, outside TB_WAIT: next state SHALL be IDLE, stage_cnt = 0, acs_grp = 0, and no transfer SHALL occur that cycle.
REQ-042 frame_start SHALL take priority over rx_valid, over norm_req and over the end-of-stage transitions.
REQ-043 frame_start in TB_WAIT SHALL be ignored.
REQ-044 acs_en and norm_en SHALL never both be 1 in the same cycle.
REQ-045 All outputs SHALL be registered, except rx_ready (combinational from state, acs_grp, norm_req and stage_cnt) and busy.

Reset
REQ-046 On rst: state = IDLE, bmc_pair = 2'b00, acs_grp = 0, stage_cnt = 0, acs_en = 0, norm_en = 0, tb_start = 0.
REQ-047 Reset asserted mid-stage or in TB_WAIT SHALL abort immediately with no further acs_en or tb_start pulse.
REQ-048 After rst deasserts, the first transfer SHALL be accepted in the first cycle that rx_valid = 1.

Verification (N_GRP = 4, FRAME_LEN = 4 override)
REQ-049 Single symbol 2'b10 accepted at cycle 0 -> acs_en = 1 in cycles 1-4 with acs_grp 0,1,2,3; bmc_pair = 2'b10; stage_cnt = 1 in cycle 5; IDLE in cycle 5.
REQ-050 Continuous rx_valid with symbols 00,01,10 -> transfers in cycles 0, 4 and 8; acs_en continuously high in cycles 1-12.
REQ-051 norm_req = 1 during stage 2, grp 3 -> norm_en in the following cycle; rx_ready = 0 in that cycle; IDLE afterwards.
REQ-052 Four stages completed -> tb_start one cycle after stage 4 ends; rx_ready held 0 until tb_done; stage_cnt = 0 after tb_done.
REQ-053 frame_start asserted at grp 2 of stage 1 together with rx_valid -> IDLE next cycle, stage_cnt = 0, no transfer; the next symbol restarts at grp 0.
REQ-054 rst asserted in TB_WAIT, tb_start and norm_req asserted in stage 4 -> all outputs at reset values immediately; no norm_en, tb_start or acs_en afterwards until a new transfer.
